// File: rtl/seg_timer_pkg.sv
// Shared definitions for the seven-segment timer: mode encodings, the segment
// decode table and per-digit BCD arithmetic helpers.
package seg_timer_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Segment pattern {g,f,e,d,c,b,a} for one BCD digit; non-BCD codes are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
    if (!cin)          bcd_digit_inc = {1'b0, d};
    else if (d >= 4'd9) bcd_digit_inc = {1'b1, 4'd0};
    else               bcd_digit_inc = {1'b0, d + 4'd1};
  endfunction

  // Returns {borrow_out, digit}.
  function automatic logic [4:0] bcd_digit_dec(input logic [3:0] d, input logic bin);
    if (!bin)           bcd_digit_dec = {1'b0, d};
    else if (d == 4'd0) bcd_digit_dec = {1'b1, 4'd9};
    else                bcd_digit_dec = {1'b0, d - 4'd1};
  endfunction

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    bcd_sat = (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/seg_timer_scan.sv
// Multiplexed seven-segment scanner: walks the digit index at the scan rate and
// registers the decoded segments and one-hot digit enable.
module seg_timer_scan
  import seg_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_count,
  input  logic                  i_running,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_digit_en
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SW-1:0]     r_scan;
  logic [IW-1:0]     r_idx;
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_en;

  logic [3:0]        w_nib;
  logic [DIGITS-1:0] w_en;
  logic              w_scan_wrap;

  assign w_scan_wrap = (r_scan == SW'(SCAN_DIV - 1));

  always_comb begin
    w_nib = '0;
    w_en  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib   = i_count[4*i +: 4];
        w_en[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_seg  <= '0;
      r_en   <= '0;
    end else begin
      if (w_scan_wrap) begin
        r_scan <= '0;
        r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end else begin
        r_scan <= r_scan + SW'(1);
      end
      r_seg <= {i_running && (r_idx == '0), seg_decode(w_nib)};
      r_en  <= w_en;
    end
  end

  assign o_seg      = r_seg;
  assign o_digit_en = r_en;

endmodule

// File: rtl/seg_timer_mux.sv
// BCD stopwatch/countdown timer: button synchronizers and edge detect, tick
// prescaler, BCD counter with wrap/done interrupts, and the display scanner.
module seg_timer_mux
  import seg_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_stop_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  mode_i,
  input  logic [4*DIGITS-1:0]   preset_i,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic                  running_o,
  output logic                  done_irq_o,
  output logic                  wrap_irq_o
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);

  // Two synchronizer stages plus the edge-detect history flop per button.
  logic [2:0]    r_ss_sync;
  logic [2:0]    r_clr_sync;
  logic [2:0]    r_ld_sync;
  logic [1:0]    r_mode_sync;

  logic [CW-1:0] r_count;
  logic          r_running;
  logic [PW-1:0] r_presc;
  logic          r_done_irq;
  logic          r_wrap_irq;

  logic          w_ss_edge;
  logic          w_clr_edge;
  logic          w_ld_edge;
  logic          w_mode;
  logic          w_tick;
  logic [CW-1:0] w_inc;
  logic [CW-1:0] w_dec;
  logic [CW-1:0] w_load;
  logic          w_wrap;

  assign w_ss_edge  = r_ss_sync[1]  & ~r_ss_sync[2];
  assign w_clr_edge = r_clr_sync[1] & ~r_clr_sync[2];
  assign w_ld_edge  = r_ld_sync[1]  & ~r_ld_sync[2];
  assign w_mode     = r_mode_sync[1];
  assign w_tick     = r_running && (r_presc == PW'(TICK_DIV - 1));

  always_comb begin : bcd_next
    logic       c;
    logic       b;
    logic [4:0] inc_d;
    logic [4:0] dec_d;
    c      = 1'b1;
    b      = 1'b1;
    inc_d  = '0;
    dec_d  = '0;
    w_inc  = '0;
    w_dec  = '0;
    w_load = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      inc_d             = bcd_digit_inc(r_count[4*i +: 4], c);
      w_inc[4*i +: 4]   = inc_d[3:0];
      c                 = inc_d[4];
      dec_d             = bcd_digit_dec(r_count[4*i +: 4], b);
      w_dec[4*i +: 4]   = dec_d[3:0];
      b                 = dec_d[4];
      w_load[4*i +: 4]  = bcd_sat(preset_i[4*i +: 4]);
    end
    w_wrap = c;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ss_sync   <= '0;
      r_clr_sync  <= '0;
      r_ld_sync   <= '0;
      r_mode_sync <= '0;
      r_count     <= '0;
      r_running   <= 1'b0;
      r_presc     <= '0;
      r_done_irq  <= 1'b0;
      r_wrap_irq  <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[1:0], start_stop_i};
      r_clr_sync  <= {r_clr_sync[1:0], clear_i};
      r_ld_sync   <= {r_ld_sync[1:0], load_i};
      r_mode_sync <= {r_mode_sync[0], mode_i};
      r_done_irq  <= 1'b0;
      r_wrap_irq  <= 1'b0;

      if (w_clr_edge) begin
        r_count   <= '0;
        r_running <= 1'b0;
        r_presc   <= '0;
      end else if (w_ld_edge) begin
        r_count <= w_load;
        r_presc <= '0;
      end else if (w_ss_edge) begin
        // A start in down mode at zero would immediately underflow; refuse it.
        if (r_running)
          r_running <= 1'b0;
        else if (!(w_mode == MODE_DOWN && r_count == '0))
          r_running <= 1'b1;
      end else if (w_tick) begin
        r_presc <= '0;
        if (w_mode == MODE_UP) begin
          r_count    <= w_inc;
          r_wrap_irq <= w_wrap;
        end else begin
          r_count <= w_dec;
          if (w_dec == '0) begin
            r_running  <= 1'b0;
            r_done_irq <= 1'b1;
          end
        end
      end else if (r_running) begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  seg_timer_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_count    (r_count),
    .i_running  (r_running),
    .o_seg      (seg_o),
    .o_digit_en (digit_en_o)
  );

  assign running_o  = r_running;
  assign done_irq_o = r_done_irq;
  assign wrap_irq_o = r_wrap_irq;

endmodule
